ex_mdu: RTL and testbench
=========================

EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 SHALL have parameter W, default 32, meaning datapath width; legal values are powers of two, 8 or more.
REQ-002 SHALL have parameter RW, default 5, meaning destination register address width.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 aluop_i  in  8  operation code.
REQ-006 alusel_i  in  3  result class: LOGIC, SHIFT, ARITH, MOVE or NOP.
REQ-007 reg1_i, reg2_i  in  W  operands.
REQ-008 wd_i  in  RW  destination address.
REQ-009 wreg_i  in  1  destination write enable.
REQ-010 hi_i, lo_i  in  W  current HI/LO values, already forwarded.
REQ-011 annul_i  in  1  flush of the instruction currently in this stage.
REQ-012 wd_o  out  RW  destination address.
REQ-013 wreg_o  out  1  destination write enable.
REQ-014 wdata_o  out  W  result.
REQ-015 whilo_o  out  1  HI/LO write enable.
REQ-016 hi_o, lo_o  out  W  HI/LO write data.
REQ-017 stallreq_o  out  1  request to hold the upstream pipeline.

Function
REQ-018 SHALL compute logic ops OR, AND, XOR, NOR on reg1_i, reg2_i in the same cycle, combinationally.
REQ-019 SHALL shift reg2_i by reg1_i[log2(W)-1:0] for SLL, SRL, SRA in the same cycle; SRA is sign-filling.
REQ-020 SHALL compute ADDU, SUBU (reg1-reg2), SLT (signed) and SLTU (result 1 or 0) modulo 2^W in the same cycle.
REQ-021 SHALL produce MULT and MULTU in the same cycle as a full 2W-bit product: hi_o = upper W bits, lo_o = lower W bits, whilo_o = 1.
REQ-022 SHALL return hi_i for MFHI and lo_i for MFLO on wdata_o; MTHI writes reg1_i to HI and keeps lo_i; MTLO writes reg1_i to LO and keeps hi_i; MTHI and MTLO assert whilo_o.
REQ-023 SHALL pass wd_i through to wd_o and wreg_i through to wreg_o; wdata_o is selected by alusel_i and is 0 for NOP or an unknown alusel_i.
REQ-024 SHALL execute DIV and DIVU iteratively with divider FSM states IDLE, BUSY, DONE, producing one quotient bit per cycle.
REQ-025 IDLE with a divide op and nonzero divisor: stallreq_o = 1 in that cycle; latch operand magnitudes; go to BUSY with counter = 0.
REQ-026 BUSY: stallreq_o = 1; one restoring step per cycle; after step W-1 go to DONE. Total stall is W+1 cycles.
REQ-027 DONE: stallreq_o = 0, whilo_o = 1, lo_o = quotient, hi_o = remainder; next state is IDLE unconditionally, so a held divide is not restarted.
REQ-028 Signed DIV: quotient negated when operand signs differ; remainder takes the dividend sign; quotient truncates toward zero.
REQ-029 Divisor 0: IDLE goes directly to DONE after one stall cycle, with lo_o = 0 and hi_o = 0.
REQ-030 annul_i = 1 in any state: stallreq_o = 0 and whilo_o = 0 in that cycle; FSM goes to IDLE next cycle; no HI/LO write occurs.
REQ-031 SHALL hold whilo_o = 0 for all ops other than MULT, MULTU, MTHI, MTLO, and a divide in DONE.

Reset
REQ-032 SHALL force, while rst = 1, all outputs to 0 and stallreq_o to 0.
REQ-033 SHALL leave the FSM in IDLE with counter and divider registers at 0 on the first clock after rst.
REQ-034 SHALL abandon an in-flight divide on rst with no HI/LO write.

Structure
REQ-035 SHALL take aluop and alusel encodings, ZeroWord and FSM state encodings from the shared defines package; this block adds no local encodings.
REQ-036 SHALL put the divider FSM, counter and restoring datapath in one sub-module, div_iter (ports: start, signed, annul, op1, op2, ready, quotient, remainder).
REQ-037 SHALL keep all other logic combinational in ex_mdu.

Verification (W=32)
REQ-038 DIVU 100/7 held while stalled -> stallreq_o high for 33 cycles, then one cycle with whilo_o=1, lo_o=14, hi_o=2.
REQ-039 DIV 0xFFFFFFF9 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-040 DIVU 5/0 -> stallreq_o high for 1 cycle, then whilo_o=1, lo_o=0, hi_o=0.
REQ-041 DIV started, annul_i=1 at BUSY cycle 10 -> stallreq_o=0 that cycle, whilo_o never asserted; the next DIVU 9/3 gives lo_o=3, hi_o=0.
REQ-042 MULT 0xFFFFFFFF x 2 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE, no stall.
REQ-043 SRA of 0x80000000 by 4 -> wdata_o=0xF8000000; SLT of 0xFFFFFFFF vs 1 -> 1; SLTU of the same -> 0.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// rtl/ex_mdu_pkg.sv - shared aluop/alusel encodings and divider FSM states
package ex_mdu_pkg;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative restoring divider, one quotient bit per cycle
module div_iter
  import ex_mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_signed,
  input  logic         i_annul,
  input  logic [W-1:0] i_op1,
  input  logic [W-1:0] i_op2,
  output logic         o_ready,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder
);

  localparam int SW = $clog2(W);

  div_state_e     r_state, w_state_next;
  logic [SW-1:0]  r_cnt;
  logic [W-1:0]   r_quo, r_rem, r_dsr;
  logic           r_neg_q, r_neg_r;

  logic           w_op1_neg, w_op2_neg, w_div_zero;
  logic [W-1:0]   w_mag1, w_mag2;
  logic [W:0]     w_part, w_diff;

  assign w_op1_neg  = i_signed & i_op1[W-1];
  assign w_op2_neg  = i_signed & i_op2[W-1];
  assign w_mag1     = w_op1_neg ? (~i_op1 + 1'b1) : i_op1;
  assign w_mag2     = w_op2_neg ? (~i_op2 + 1'b1) : i_op2;
  assign w_div_zero = (i_op2 == '0);

  // Partial remainder shifted left with the next dividend bit; no borrow means the quotient bit is 1.
  assign w_part = {r_rem, r_quo[W-1]};
  assign w_diff = w_part - {1'b0, r_dsr};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: if (i_start) w_state_next = w_div_zero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (r_cnt == SW'(W - 1)) w_state_next = DIV_DONE;
      DIV_DONE: w_state_next = DIV_IDLE;
      default:  w_state_next = DIV_IDLE;
    endcase
    if (i_annul) w_state_next = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dsr   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == DIV_IDLE && i_start && !i_annul) begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_dsr   <= w_mag2;
        r_quo   <= w_div_zero ? '0 : w_mag1;
        r_neg_q <= !w_div_zero && (w_op1_neg ^ w_op2_neg);
        r_neg_r <= !w_div_zero && w_op1_neg;
      end else if (r_state == DIV_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (!w_diff[W]) begin
          r_rem <= w_diff[W-1:0];
          r_quo <= {r_quo[W-2:0], 1'b1};
        end else begin
          r_rem <= w_part[W-1:0];
          r_quo <= {r_quo[W-2:0], 1'b0};
        end
      end
    end
  end

  assign o_ready     = (r_state == DIV_DONE) && !i_annul;
  assign o_quotient  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign o_remainder = r_neg_r ? (~r_rem + 1'b1) : r_rem;

endmodule

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - execute stage: logic/shift/arith/move, single-cycle multiply, iterative divide
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    aluop_i,
  input  logic [2:0]    alusel_i,
  input  logic [W-1:0]  reg1_i,
  input  logic [W-1:0]  reg2_i,
  input  logic [RW-1:0] wd_i,
  input  logic          wreg_i,
  input  logic [W-1:0]  hi_i,
  input  logic [W-1:0]  lo_i,
  input  logic          annul_i,
  output logic [RW-1:0] wd_o,
  output logic          wreg_o,
  output logic [W-1:0]  wdata_o,
  output logic          whilo_o,
  output logic [W-1:0]  hi_o,
  output logic [W-1:0]  lo_o,
  output logic          stallreq_o
);

  localparam int SW = $clog2(W);

  logic           w_is_div, w_div_ready;
  logic [W-1:0]   w_quot, w_rem;
  logic [W-1:0]   w_logic, w_shift, w_arith, w_move;
  logic [SW-1:0]  w_shamt;
  logic [2*W-1:0] w_ext1, w_ext2, w_prod;

  assign w_is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);

  div_iter #(.W(W)) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_is_div),
    .i_signed    (aluop_i == OP_DIV),
    .i_annul     (annul_i),
    .i_op1       (reg1_i),
    .i_op2       (reg2_i),
    .o_ready     (w_div_ready),
    .o_quotient  (w_quot),
    .o_remainder (w_rem)
  );

  assign w_shamt = reg1_i[SW-1:0];

  // Sign- or zero-extend to 2W so one truncated product serves both MULT and MULTU.
  assign w_ext1 = (aluop_i == OP_MULT) ? {{W{reg1_i[W-1]}}, reg1_i} : {{W{1'b0}}, reg1_i};
  assign w_ext2 = (aluop_i == OP_MULT) ? {{W{reg2_i[W-1]}}, reg2_i} : {{W{1'b0}}, reg2_i};
  assign w_prod = w_ext1 * w_ext2;

  always_comb begin
    w_logic = '0;
    w_shift = '0;
    w_arith = '0;
    w_move  = '0;
    case (aluop_i)
      OP_OR:   w_logic = reg1_i | reg2_i;
      OP_AND:  w_logic = reg1_i & reg2_i;
      OP_XOR:  w_logic = reg1_i ^ reg2_i;
      OP_NOR:  w_logic = ~(reg1_i | reg2_i);
      OP_SLL:  w_shift = reg2_i << w_shamt;
      OP_SRL:  w_shift = reg2_i >> w_shamt;
      OP_SRA:  w_shift = $signed(reg2_i) >>> w_shamt;
      OP_ADDU: w_arith = reg1_i + reg2_i;
      OP_SUBU: w_arith = reg1_i - reg2_i;
      OP_SLT:  w_arith = {{(W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      OP_SLTU: w_arith = {{(W-1){1'b0}}, (reg1_i < reg2_i)};
      OP_MFHI: w_move  = hi_i;
      OP_MFLO: w_move  = lo_i;
      default: ;
    endcase
  end

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = w_is_div && !annul_i && !w_div_ready;

    case (alusel_i)
      SEL_LOGIC: wdata_o = w_logic;
      SEL_SHIFT: wdata_o = w_shift;
      SEL_ARITH: wdata_o = w_arith;
      SEL_MOVE:  wdata_o = w_move;
      default:   wdata_o = '0;
    endcase

    if (!annul_i) begin
      case (aluop_i)
        OP_MULT, OP_MULTU: begin
          whilo_o      = 1'b1;
          {hi_o, lo_o} = w_prod;
        end
        OP_MTHI: begin
          whilo_o = 1'b1;
          hi_o    = reg1_i;
          lo_o    = lo_i;
        end
        OP_MTLO: begin
          whilo_o = 1'b1;
          hi_o    = hi_i;
          lo_o    = reg1_i;
        end
        OP_DIV, OP_DIVU: begin
          whilo_o = w_div_ready;
          hi_o    = w_div_ready ? w_rem : '0;
          lo_o    = w_div_ready ? w_quot : '0;
        end
        default: ;
      endcase
    end

    if (rst) begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - directed self-checking bench for ex_mdu
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int W  = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    aluop_i;
  logic [2:0]    alusel_i;
  logic [W-1:0]  reg1_i, reg2_i, hi_i, lo_i;
  logic [RW-1:0] wd_i;
  logic          wreg_i, annul_i;
  logic [RW-1:0] wd_o;
  logic          wreg_o, whilo_o, stallreq_o;
  logic [W-1:0]  wdata_o, hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  ex_mdu #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i), .annul_i(annul_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
    .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a new op just after a rising edge, then sample on the following falling edge.
  task automatic op(input logic [7:0] a, input logic [2:0] s, input logic [W-1:0] r1, input logic [W-1:0] r2);
    @(posedge clk); #1;
    aluop_i = a; alusel_i = s; reg1_i = r1; reg2_i = r2;
    @(negedge clk);
  endtask

  task automatic wait_div(input string tag, input int exp_stall,
                          input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    n = 0;
    while (stallreq_o === 1'b1 && n < 60) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_stall"}, 64'(n), 64'(exp_stall));
    chk({tag, "_whilo"}, 64'(whilo_o), 64'd1);
    chk({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
    chk({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
  endtask

  initial begin
    rst = 1'b1; annul_i = 1'b0; aluop_i = OP_MULT; alusel_i = SEL_LOGIC;
    reg1_i = 32'hFFFF_FFFF; reg2_i = 32'd2; wd_i = 5'd17; wreg_i = 1'b1;
    hi_i = 32'h1234_5678; lo_i = 32'h9ABC_DEF0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {wd_o, wreg_o, whilo_o, stallreq_o, wdata_o, hi_o, lo_o} == '0 ? 64'd0 : 64'd1, 64'd0);
    @(posedge clk); #1; rst = 1'b0;

    op(OP_OR,  SEL_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF); chk("or",  64'(wdata_o), 64'h00FF_F0FF);
    chk("wd_pass", 64'(wd_o), 64'd17);
    chk("wreg_pass", 64'(wreg_o), 64'd1);
    chk("or_whilo", 64'(whilo_o), 64'd0);
    op(OP_AND, SEL_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF); chk("and", 64'(wdata_o), 64'h0000_00F0);
    op(OP_XOR, SEL_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF); chk("xor", 64'(wdata_o), 64'h00FF_F00F);
    op(OP_NOR, SEL_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF); chk("nor", 64'(wdata_o), 64'hFF00_0F00);
    op(OP_OR,  SEL_NOP,   32'h0000_F0F0, 32'h00FF_00FF); chk("nop_sel", 64'(wdata_o), 64'd0);
    op(OP_OR,  3'b111,    32'h0000_F0F0, 32'h00FF_00FF); chk("bad_sel", 64'(wdata_o), 64'd0);

    op(OP_SLL, SEL_SHIFT, 32'd4,  32'h8000_0001); chk("sll", 64'(wdata_o), 64'h0000_0010);
    op(OP_SRL, SEL_SHIFT, 32'd36, 32'h8000_0001); chk("srl_amt_low5", 64'(wdata_o), 64'h0800_0000);
    op(OP_SRA, SEL_SHIFT, 32'd4,  32'h8000_0000); chk("sra", 64'(wdata_o), 64'hF800_0000);

    op(OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2);  chk("addu_wrap", 64'(wdata_o), 64'd1);
    op(OP_SUBU, SEL_ARITH, 32'd1, 32'd2);          chk("subu_wrap", 64'(wdata_o), 64'hFFFF_FFFF);
    op(OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'd1);  chk("slt", 64'(wdata_o), 64'd1);
    op(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1);  chk("sltu", 64'(wdata_o), 64'd0);

    op(OP_MULT, SEL_NOP, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mult_whilo", 64'(whilo_o), 64'd1);
    chk("mult_stall", 64'(stallreq_o), 64'd0);
    op(OP_MULTU, SEL_NOP, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);

    op(OP_MFHI, SEL_MOVE, 32'd0, 32'd0); chk("mfhi", 64'(wdata_o), 64'h1234_5678);
    op(OP_MFLO, SEL_MOVE, 32'd0, 32'd0); chk("mflo", 64'(wdata_o), 64'h9ABC_DEF0);
    op(OP_MTHI, SEL_NOP, 32'hCAFE_BABE, 32'd0);
    chk("mthi", {31'd0, whilo_o, hi_o, lo_o} >> 0 == {31'd0, 1'b1, 32'hCAFE_BABE, 32'h9ABC_DEF0} ? 64'd1 : 64'd0, 64'd1);
    op(OP_MTLO, SEL_NOP, 32'hCAFE_BABE, 32'd0);
    chk("mtlo", {hi_o, lo_o}, 64'h1234_5678_CAFE_BABE);

    op(OP_DIVU, SEL_NOP, 32'd100, 32'd7);
    wait_div("divu100_7", 33, 32'd14, 32'd2);
    op(OP_NOP, SEL_NOP, 32'd0, 32'd0); chk("after_div_whilo", 64'(whilo_o), 64'd0);

    op(OP_DIV, SEL_NOP, 32'hFFFF_FFF9, 32'd2);
    wait_div("div_neg7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    op(OP_NOP, SEL_NOP, 32'd0, 32'd0);

    op(OP_DIVU, SEL_NOP, 32'd5, 32'd0);
    wait_div("divu5_0", 1, 32'd0, 32'd0);
    op(OP_NOP, SEL_NOP, 32'd0, 32'd0);

    op(OP_DIV, SEL_NOP, 32'd50, 32'd3);
    repeat (10) @(negedge clk);
    chk("annul_pre_stall", 64'(stallreq_o), 64'd1);
    @(posedge clk); #1; annul_i = 1'b1;
    @(negedge clk);
    chk("annul_stall", 64'(stallreq_o), 64'd0);
    chk("annul_whilo", 64'(whilo_o), 64'd0);
    @(posedge clk); #1; annul_i = 1'b0; aluop_i = OP_NOP;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (whilo_o !== 1'b0) n++;
    end
    chk("annul_no_write", 64'(n), 64'd0);
    op(OP_DIVU, SEL_NOP, 32'd9, 32'd3);
    wait_div("divu9_3", 33, 32'd3, 32'd0);
    op(OP_NOP, SEL_NOP, 32'd0, 32'd0);

    op(OP_DIVU, SEL_NOP, 32'd77, 32'd5);
    repeat (5) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1; aluop_i = OP_NOP;
    @(negedge clk);
    chk("rst_mid_stall", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (whilo_o !== 1'b0) n++;
    end
    chk("rst_no_write", 64'(n), 64'd0);
    op(OP_DIVU, SEL_NOP, 32'd77, 32'd5);
    wait_div("divu77_5", 33, 32'd15, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
